// File: rtl/proc_pkg.sv
// Shared definitions for the PC sequencer: state encoding, next-PC select
// encoding and the default reset address.
package proc_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0040_0020;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        HALT
    } seq_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_PLUS4,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_REG
    } pc_sel_e;

    // Any select that leaves the sequential PC+4 stream forces a flush.
    function automatic logic is_redirect(input pc_sel_e sel);
        return (sel == SEL_BRANCH) || (sel == SEL_JUMP) || (sel == SEL_REG);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control inputs and PC/status outputs of the PC sequencer, grouped as one bus.
interface pc_sequencer_if;
    import proc_pkg::*;

    logic            stall;
    logic            halt;
    logic            branch;
    logic            branch_ne;
    logic            zero;
    logic            ext_op;
    logic [15:0]     imm16;
    logic            jump;
    logic [25:0]     target26;
    logic            jump_reg;
    logic [PC_W-1:0] reg_target;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4;
    logic            flush;
    logic            halted;
    logic            misalign_err;

    modport master (
        output stall, halt, branch, branch_ne, zero, ext_op, imm16,
               jump, target26, jump_reg, reg_target,
        input  pc, pc_plus4, flush, halted, misalign_err
    );

    modport slave (
        input  stall, halt, branch, branch_ne, zero, ext_op, imm16,
               jump, target26, jump_reg, reg_target,
        output pc, pc_plus4, flush, halted, misalign_err
    );

endinterface

// File: rtl/offset_extender.sv
// Branch offset extension: word offset shifted to bytes, then sign- or
// zero-extended to the PC width.
module offset_extender
    import proc_pkg::*;
(
    input  logic [15:0]     imm16_i,
    input  logic            ext_op_i,
    output logic [PC_W-1:0] off32_o
);

    assign off32_o = {{(PC_W - 18){ext_op_i & imm16_i[15]}}, imm16_i, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// PC register, next-PC selection, and HOLD/RUN/HALT sequencing.
module pc_sequencer
    import proc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);

    seq_state_e      state_q;
    logic [PC_W-1:0] pc_q;
    logic            flush_q;
    logic            halted_q;
    logic            misalign_q;

    pc_sel_e         sel_d;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] off32;
    logic [PC_W-1:0] branch_tgt;
    logic [PC_W-1:0] jump_tgt;
    logic [PC_W-1:0] reg_tgt;
    logic            taken;

    offset_extender u_offset_extender (
        .imm16_i  (bus.imm16),
        .ext_op_i (bus.ext_op),
        .off32_o  (off32)
    );

    assign pc_plus4   = pc_q + 32'd4;
    assign branch_tgt = pc_plus4 + off32;
    assign jump_tgt   = {pc_plus4[31:28], bus.target26, 2'b00};
    assign reg_tgt    = {bus.reg_target[31:2], 2'b00};
    assign taken      = bus.branch & (bus.zero ^ bus.branch_ne);

    // Only consulted in RUN; HOLD and HALT never advance the PC.
    always_comb begin
        sel_d = SEL_PLUS4;
        if (bus.halt || bus.stall) begin
            sel_d = SEL_HOLD;
        end else if (bus.jump_reg) begin
            sel_d = SEL_REG;
        end else if (bus.jump) begin
            sel_d = SEL_JUMP;
        end else if (taken) begin
            sel_d = SEL_BRANCH;
        end

        pc_d = pc_plus4;
        case (sel_d)
            SEL_HOLD:   pc_d = pc_q;
            SEL_REG:    pc_d = reg_tgt;
            SEL_JUMP:   pc_d = jump_tgt;
            SEL_BRANCH: pc_d = branch_tgt;
            default:    pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HOLD;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    state_q <= RUN;
                    flush_q <= 1'b0;
                end
                RUN: begin
                    pc_q    <= pc_d;
                    flush_q <= is_redirect(sel_d);
                    if (bus.halt && !bus.stall) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                    if ((sel_d == SEL_REG) && (bus.reg_target[1:0] != 2'b00)) begin
                        misalign_q <= 1'b1;
                    end
                end
                HALT: begin
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q <= HOLD;
                end
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.flush        = flush_q;
    assign bus.halted       = halted_q;
    assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model pushes expected
// outputs each cycle, popped and compared one edge later.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_sequencer_if sif ();

    pc_sequencer #(.RESET_PC(32'h0040_0020)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        halted;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    int          m_state = 0;
    logic [31:0] m_pc = 32'h0040_0020;
    logic        m_flush = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_mis = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_idle();
        sif.stall      = 1'b0;
        sif.halt       = 1'b0;
        sif.branch     = 1'b0;
        sif.branch_ne  = 1'b0;
        sif.zero       = 1'b0;
        sif.ext_op     = 1'b0;
        sif.imm16      = 16'h0000;
        sif.jump       = 1'b0;
        sif.target26   = 26'h0;
        sif.jump_reg   = 1'b0;
        sif.reg_target = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] off;
        logic [31:0] np4;
        np4 = m_pc + 32'd4;
        off = sif.ext_op ? {{14{sif.imm16[15]}}, sif.imm16, 2'b00}
                         : {14'b0, sif.imm16, 2'b00};
        if (rst) begin
            m_state = 0; m_pc = 32'h0040_0020;
            m_flush = 0; m_halted = 0; m_mis = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_flush = 0;
        end else if (m_state == 2) begin
            m_flush = 0;
        end else if (sif.halt) begin
            m_flush = 0;
            if (!sif.stall) begin
                m_state = 2; m_halted = 1;
            end
        end else if (sif.stall) begin
            m_flush = 0;
        end else if (sif.jump_reg) begin
            m_pc = sif.reg_target & 32'hFFFF_FFFC;
            m_flush = 1;
            if (sif.reg_target[1:0] != 2'b00) m_mis = 1;
        end else if (sif.jump) begin
            m_pc = {np4[31:28], sif.target26, 2'b00};
            m_flush = 1;
        end else if (sif.branch && (sif.zero != sif.branch_ne)) begin
            m_pc = np4 + off;
            m_flush = 1;
        end else begin
            m_pc = np4;
            m_flush = 0;
        end
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        model_step();
        e.pc = m_pc; e.flush = m_flush; e.halted = m_halted; e.mis = m_mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc"}, sif.pc, e.pc);
            chk({tag, "_pc4"}, sif.pc_plus4, e.pc + 32'd4);
            chk({tag, "_flush"}, {31'd0, sif.flush}, {31'd0, e.flush});
            chk({tag, "_halted"}, {31'd0, sif.halted}, {31'd0, e.halted});
            chk({tag, "_mis"}, {31'd0, sif.misalign_err}, {31'd0, e.mis});
        end
    endtask

    task automatic jr_to(input logic [31:0] addr);
        set_idle();
        sif.jump_reg   = 1'b1;
        sif.reg_target = addr;
        cycle("jr");
        set_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        rst = 1'b1;
        cycle("rst0");
        cycle("rst1");
        chk("reset_pc", sif.pc, 32'h0040_0020);
        chk("reset_flush", {31'd0, sif.flush}, 32'd0);

        rst = 1'b0;
        cycle("hold");
        chk("hold_pc", sif.pc, 32'h0040_0020);
        cycle("run1");
        chk("run1_pc", sif.pc, 32'h0040_0024);
        cycle("run2");
        cycle("run3");
        chk("run3_pc", sif.pc, 32'h0040_002C);

        // beq taken backward onto itself
        jr_to(32'h0040_0030);
        sif.branch = 1'b1; sif.zero = 1'b1; sif.ext_op = 1'b1; sif.imm16 = 16'hFFFF;
        cycle("beq_back");
        chk("beq_back_const", sif.pc, 32'h0040_0030);
        chk("beq_back_flush", {31'd0, sif.flush}, 32'd1);
        sif.branch_ne = 1'b1;
        cycle("bne_not_taken");
        chk("bne_nt_const", sif.pc, 32'h0040_0034);
        set_idle();
        cycle("after_br");

        // sign vs zero extension of 0x8000
        jr_to(32'h0040_0000);
        sif.branch = 1'b1; sif.zero = 1'b1; sif.ext_op = 1'b1; sif.imm16 = 16'h8000;
        cycle("sext");
        chk("sext_const", sif.pc, 32'h003E_0004);
        jr_to(32'h0040_0000);
        sif.branch = 1'b1; sif.zero = 1'b1; sif.ext_op = 1'b0; sif.imm16 = 16'h8000;
        cycle("zext");
        chk("zext_const", sif.pc, 32'h0042_0004);

        // priority: jump_reg over jump over taken branch
        set_idle();
        sif.jump_reg = 1'b1; sif.reg_target = 32'h0040_1002;
        sif.jump = 1'b1; sif.target26 = 26'h0000_200;
        sif.branch = 1'b1; sif.zero = 1'b1; sif.imm16 = 16'h0010;
        cycle("prio");
        chk("prio_const", sif.pc, 32'h0040_1000);
        chk("prio_mis", {31'd0, sif.misalign_err}, 32'd1);
        set_idle();
        sif.stall = 1'b1; sif.jump = 1'b1; sif.target26 = 26'h0000_200;
        cycle("stall_jump");
        chk("stall_pc", sif.pc, 32'h0040_1000);
        chk("stall_flush", {31'd0, sif.flush}, 32'd0);
        set_idle();
        sif.stall = 1'b1; sif.halt = 1'b1;
        cycle("stall_halt");
        chk("stall_halt_h", {31'd0, sif.halted}, 32'd0);
        set_idle();
        cycle("resume");

        // jump keeps the upper region nibble
        jr_to(32'hF000_0010);
        sif.jump = 1'b1; sif.target26 = 26'h0000_100;
        cycle("jregion");
        chk("jregion_const", sif.pc, 32'hF000_0400);

        // wrap at the top of the address space
        jr_to(32'hFFFF_FFFC);
        cycle("wrap");
        chk("wrap_const", sif.pc, 32'h0000_0000);

        // halt, then ignore redirects, then reset out of HALT
        jr_to(32'h0040_0040);
        sif.halt = 1'b1;
        cycle("halt");
        chk("halt_h", {31'd0, sif.halted}, 32'd1);
        set_idle();
        sif.branch = 1'b1; sif.zero = 1'b1; sif.imm16 = 16'h0004;
        sif.jump = 1'b1; sif.target26 = 26'h0000_300; sif.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle("halted");
            chk("halted_pc", sif.pc, 32'h0040_0040);
            sif.stall = ~sif.stall;
        end
        set_idle();
        rst = 1'b1;
        cycle("rst_halt");
        chk("rst_halt_pc", sif.pc, 32'h0040_0020);
        chk("rst_halt_h", {31'd0, sif.halted}, 32'd0);
        chk("rst_halt_mis", {31'd0, sif.misalign_err}, 32'd0);
        rst = 1'b0;
        cycle("hold2");
        cycle("run_again");
        chk("run_again_pc", sif.pc, 32'h0040_0024);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
